// File: rtl/i2c_write_engine.sv
// ---------------------------------------------------------------------------
// i2c_write_engine
//   Single-clock I2C master. Each request sends one 3-byte write:
//   slave address + W, sub address, data. Bytes go out MSB first, and each
//   byte is followed by one acknowledge slot.
//   All bus timing comes from a quarter-bit clock enable (tick) generated on
//   the system clock. No derived clock is used.
//
// Ports
//   CLOCK_50  in     system clock; all logic runs on its rising edge
//   reset     in     synchronous active-high reset
//   I2C_DATA  in     {slave_addr+W, sub_addr, data}; captured when a transfer starts
//   GO        in     level request; a transfer starts when GO=1 in IDLE
//   END       out    transfer complete; held until GO is seen low
//   ACK       out    1 when at least one ack slot read NACK; valid while END=1
//   BUSY      out    high in every state except IDLE
//   I2C_SCLK  out    SCL, push-pull
//   I2C_SDAT  inout  SDA, open-drain; only ever driven low or released
// ---------------------------------------------------------------------------
module i2c_write_engine #(
    parameter int CLK_Freq = 50000000,
    parameter int I2C_Freq = 20000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [23:0] I2C_DATA,
    input  logic        GO,
    output logic        END,
    output logic        ACK,
    output logic        BUSY,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT
);

    localparam int DIV = CLK_Freq / (4 * I2C_Freq);
    localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BITS,
        S_STOP,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [DW-1:0]  div_q, div_d;
    logic [1:0]     qcnt_q;       // quarter index inside the current phase
    logic [4:0]     bitcnt_q;     // slot 0..26 over the whole transfer
    logic [3:0]     bpos_q;       // slot 0..8 inside the current byte; 8 = ack slot
    logic [23:0]    shreg_q;
    logic           sda_oe_q;     // 1 = pull SDA low
    logic           scl_q;
    logic           end_q;
    logic           ack_q;
    logic           busy_q;

    logic           tick;
    logic           ack_slot;

    assign tick     = (div_q == DW'(DIV - 1));
    assign ack_slot = (bpos_q == 4'd8);

    // The divider only runs while the bus is active, so the first tick of a
    // transfer always comes exactly DIV clocks after GO is sampled.
    always_comb begin
        div_d = div_q;
        if (state_q == S_IDLE || state_q == S_DONE || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            qcnt_q   <= 2'd0;
            bitcnt_q <= 5'd0;
            bpos_q   <= 4'd0;
            shreg_q  <= 24'd0;
            sda_oe_q <= 1'b0;
            scl_q    <= 1'b1;
            end_q    <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            div_q <= div_d;
            case (state_q)
                S_IDLE: begin
                    end_q <= 1'b0;
                    if (GO) begin
                        shreg_q  <= I2C_DATA;
                        ack_q    <= 1'b0;
                        bitcnt_q <= 5'd0;
                        bpos_q   <= 4'd0;
                        qcnt_q   <= 2'd0;
                        busy_q   <= 1'b1;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (qcnt_q == 2'd0) begin
                            sda_oe_q <= 1'b1;       // SDA falls while SCL is high
                            qcnt_q   <= 2'd1;
                        end else begin
                            scl_q    <= 1'b0;
                            qcnt_q   <= 2'd0;
                            state_q  <= S_BITS;
                        end
                    end
                end
                S_BITS: begin
                    if (tick) begin
                        qcnt_q <= qcnt_q + 2'd1;    // wraps 3 -> 0 at slot end
                        case (qcnt_q)
                            2'd0: sda_oe_q <= ack_slot ? 1'b0 : ~shreg_q[23];
                            2'd1: scl_q    <= 1'b1;
                            2'd2: begin
                                if (ack_slot) begin
                                    ack_q <= ack_q | I2C_SDAT;
                                end
                            end
                            default: begin
                                scl_q <= 1'b0;
                                if (!ack_slot) begin
                                    shreg_q <= {shreg_q[22:0], 1'b0};
                                end
                                bpos_q   <= ack_slot ? 4'd0 : bpos_q + 4'd1;
                                bitcnt_q <= bitcnt_q + 5'd1;
                                if (bitcnt_q == 5'd26) begin
                                    state_q <= S_STOP;
                                end
                            end
                        endcase
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        case (qcnt_q)
                            2'd0: begin
                                sda_oe_q <= 1'b1;
                                qcnt_q   <= 2'd1;
                            end
                            2'd1: begin
                                scl_q  <= 1'b1;
                                qcnt_q <= 2'd2;
                            end
                            default: begin
                                sda_oe_q <= 1'b0;   // SDA rises while SCL is high
                                qcnt_q   <= 2'd0;
                                state_q  <= S_DONE;
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    end_q <= 1'b1;
                    // Waiting for GO low keeps a held request from restarting.
                    if (!GO) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign END      = end_q;
    assign ACK      = ack_q;
    assign BUSY     = busy_q;
    assign I2C_SCLK = scl_q;
    assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_write_engine.sv
// ---------------------------------------------------------------------------
// tb_i2c_write_engine
//   Drives write requests into i2c_write_engine at DIV=2. A bus monitor
//   decodes START/bytes/STOP on SCL/SDA and plays an acking slave. Expected
//   bytes are queued when a request is issued and popped as bytes decode.
// ---------------------------------------------------------------------------
module tb_i2c_write_engine;

    localparam int CLK_F = 80000;
    localparam int I2C_F = 10000;
    localparam int DIV   = CLK_F / (4 * I2C_F);   // 2
    localparam int LAT   = 113 * DIV + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [23:0] data;
    logic        done;
    logic        ack;
    logic        busy;
    logic        scl;
    wire         sda;
    logic        slave_low = 1'b0;

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    i2c_write_engine #(.CLK_Freq(CLK_F), .I2C_Freq(I2C_F)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .I2C_DATA (data),
        .GO       (go),
        .END      (done),
        .ACK      (ack),
        .BUSY     (busy),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and slave behaviour
    logic [7:0] exp_q[$];
    logic [2:0] nack_mask = 3'b000;

    // Bus monitor state
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic [8:0] rx = 9'd0;
    int         bitn = 0;
    int         byte_idx = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         rise_cnt = 0;

    always @(negedge clk) begin
        if (scl && prev_scl && !sda && prev_sda) begin
            start_cnt++;
            bitn      = 0;
            byte_idx  = 0;
            slave_low = 1'b0;
            $display("bus START at cycle %0d", cyc);
        end else if (scl && prev_scl && sda && !prev_sda) begin
            stop_cnt++;
            $display("bus STOP at cycle %0d after %0d bytes", cyc, byte_idx);
            check("stop_after_3_bytes", 32'(byte_idx), 32'd3);
        end else if (scl && !prev_scl) begin
            rise_cnt++;
            rx = {rx[7:0], sda};
            bitn++;
            if (bitn == 9) begin
                $display("bus byte %0d = %02h ack_bit=%0b", byte_idx, rx[8:1], rx[0]);
                if (exp_q.size() == 0) begin
                    check("byte_unexpected", 32'd1, 32'd0);
                end else begin
                    check($sformatf("byte%0d", byte_idx), 32'(rx[8:1]), 32'(exp_q.pop_front()));
                end
            end
        end else if (!scl && prev_scl) begin
            if (bitn == 8 && byte_idx < 3) begin
                slave_low = !nack_mask[byte_idx];
            end else if (bitn == 9) begin
                slave_low = 1'b0;
                bitn      = 0;
                byte_idx++;
            end
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    // One full request. mode: 0 = drop GO after END, 1 = hold GO after END,
    // 2 = one-cycle GO pulse.
    task automatic do_xfer(input logic [23:0] d, input logic [2:0] nm, input int mode);
        int  s0, st0, sp0, r0;
        bit  seen;
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
        nack_mask = nm;
        st0  = start_cnt;
        sp0  = stop_cnt;
        data = d;
        go   = 1'b1;
        @(negedge clk);
        s0 = cyc;
        if (mode == 2) go = 1'b0;
        data = ~d;                              // must not reach the bus
        check("busy_running", 32'(busy), 32'd1);
        seen = 1'b0;
        for (int t = 0; t < 2000 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("end_seen", 32'(seen), 32'd1);
        check("end_latency", 32'(cyc - s0), 32'(LAT));
        check("ack_status", 32'(ack), 32'(nm != 3'b000));
        check("start_count", 32'(start_cnt - st0), 32'd1);
        check("stop_count", 32'(stop_cnt - sp0), 32'd1);
        check("bytes_consumed", 32'(exp_q.size()), 32'd0);
        $display("xfer data=%06h nack=%03b latency=%0d ack=%0b", d, nm, cyc - s0, ack);
        if (mode == 2) begin
            @(negedge clk);
            check("end_one_cycle", 32'(done), 32'd0);
            check("busy_after_pulse", 32'(busy), 32'd0);
        end else if (mode == 1) begin
            r0 = rise_cnt;
            repeat (6) @(negedge clk);
            check("hold_end", 32'(done), 32'd1);
            check("hold_busy", 32'(busy), 32'd1);
            check("hold_scl_quiet", 32'(rise_cnt - r0), 32'd0);
            check("hold_scl_high", 32'(scl), 32'd1);
            go = 1'b0;
            @(negedge clk);
            check("drop_busy", 32'(busy), 32'd0);
            @(negedge clk);
            check("drop_end", 32'(done), 32'd0);
        end else begin
            go = 1'b0;
            @(negedge clk);
            check("idle_busy", 32'(busy), 32'd0);
            @(negedge clk);
            check("idle_end", 32'(done), 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int r0;
        rst  = 1'b1;
        go   = 1'b0;
        data = 24'd0;

        // Reset levels
        repeat (3) @(negedge clk);
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_end", 32'(done), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic write, all acked
        do_xfer(24'h340C55, 3'b000, 0);
        // NACK on second byte, then a clean transfer clears ACK
        do_xfer(24'h340C55, 3'b010, 0);
        do_xfer(24'h9A3C7E, 3'b000, 0);
        // GO held after END, then a fresh transfer
        do_xfer(24'h5AF00F, 3'b100, 1);
        do_xfer(24'hFF0080, 3'b001, 0);

        // Reset in the middle of slot 10
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        nack_mask = 3'b000;
        data = 24'h112233;
        go   = 1'b1;
        r0   = rise_cnt;
        seen = 1'b0;
        for (int t = 0; t < 500 && !seen; t++) begin
            @(negedge clk);
            if (rise_cnt - r0 >= 10) seen = 1'b1;
        end
        check("reach_slot10", 32'(seen), 32'd1);
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            if (!scl) seen = 1'b1;
            else @(negedge clk);
        end
        rst = 1'b1;
        go  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_scl", 32'(scl), 32'd1);
        check("abort_sda", 32'(sda), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_end", 32'(done), 32'd0);
        $display("xfer aborted by reset at cycle %0d", cyc);
        exp_q.delete();
        repeat (4) @(negedge clk);
        do_xfer(24'h40AA01, 3'b000, 0);

        // One-cycle GO pulse
        do_xfer(24'h12A5F0, 3'b000, 2);

        // A few random transfers
        for (int i = 0; i < 3; i++) begin
            do_xfer(24'($urandom), 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
